dma_channel_regfile: RTL

//  Parametrised channel register file for the DMA datapath. Generalises the 4-ch/16-bit 8237A register set to
//  NUM_CH channels and configurable address/count widths. Holds Command, Status and per-channel Mode/Base/Current

---
 rtl/dma_channel_regfile.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dma_channel_regfile.sv
// DMA channel register file: command/status, per-channel mode/base/current, byte-serial CPU access, transfer stepping.
// CpuDout, Tc and AdstbReq are one cycle after their cause; ActAddr/ActCount are combinational; no backpressure.
module dma_channel_regfile #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                                        Clock,
    input  logic                                        Reset,
    input  logic                                        MasterClear,
    input  logic                                        CpuWr,
    input  logic                                        CpuRd,
    input  logic [2:0]                                  RegSel,
    input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0] ChSel,
    input  logic [7:0]                                  CpuDin,
    output logic [7:0]                                  CpuDout,
    input  logic                                        Step,
    input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0] StepCh,
    output logic [ADDR_W-1:0]                           ActAddr,
    output logic [CNT_W-1:0]                            ActCount,
    output logic [7:0]                                  Command,
    output logic [6*NUM_CH-1:0]                         Mode,
    output logic                                        Tc,
    output logic                                        AdstbReq
);

    localparam int CH_W   = $clog2(NUM_CH > 1 ? NUM_CH : 2);
    localparam int NCH_P  = 2 ** CH_W;
    localparam int AB     = ADDR_W / 8;
    localparam int CB     = CNT_W / 8;
    localparam int MAXB   = (AB > CB) ? AB : CB;
    localparam int PW     = $clog2(MAXB > 1 ? MAXB : 2);

    localparam logic [2:0] REG_ADDR   = 3'd0;
    localparam logic [2:0] REG_COUNT  = 3'd1;
    localparam logic [2:0] REG_MODE   = 3'd2;
    localparam logic [2:0] REG_CMD    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_CLRPTR = 3'd5;

    // Arrays are padded to a power of two so ChSel/StepCh indexing is always in range;
    // the padding entries are never written and stay at their reset value.
    logic [7:0]        command_q;
    logic [NUM_CH-1:0] tc_flags_q;
    logic [5:0]        mode_q      [NCH_P];
    logic [ADDR_W-1:0] base_addr_q [NCH_P];
    logic [ADDR_W-1:0] cur_addr_q  [NCH_P];
    logic [CNT_W-1:0]  base_cnt_q  [NCH_P];
    logic [CNT_W-1:0]  cur_cnt_q   [NCH_P];
    logic [PW-1:0]     ptr_q;
    logic [7:0]        cpu_dout_q;
    logic              tc_q;
    logic              adstb_q;

    logic              clr;
    logic              wr_addr, wr_cnt, rd_only, rd_status, ch_ok;
    logic              step_ok, step_tc, step_reload, addr_carry;
    logic [5:0]        step_mode;
    logic [ADDR_W-1:0] step_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  rd_cnt;
    logic [NUM_CH-1:0] tc_set;
    logic [7:0]        status_byte;
    logic [7:0]        rd_byte;
    logic [PW-1:0]     ptr_d;
    int                last_byte;

    assign clr       = Reset | MasterClear;
    assign wr_addr   = CpuWr && (RegSel == REG_ADDR);
    assign wr_cnt    = CpuWr && (RegSel == REG_COUNT);
    assign rd_only   = CpuRd && !CpuWr;
    assign rd_status = rd_only && (RegSel == REG_STATUS);
    assign ch_ok     = int'(ChSel) < NUM_CH;

    assign ActAddr   = cur_addr_q[StepCh];
    assign ActCount  = cur_cnt_q[StepCh];
    assign step_mode = mode_q[StepCh];
    assign rd_addr   = cur_addr_q[ChSel];
    assign rd_cnt    = cur_cnt_q[ChSel];

    // A CPU write to the serviced channel's addr/count pre-empts the whole step.
    assign step_ok     = Step && !command_q[2] && (int'(StepCh) < NUM_CH)
                         && !((wr_addr || wr_cnt) && (ChSel == StepCh));
    assign step_tc     = (ActCount == '0);
    assign step_reload = step_tc && step_mode[2];
    assign step_addr   = step_mode[3] ? ActAddr - ADDR_W'(1) : ActAddr + ADDR_W'(1);
    assign addr_carry  = |((step_addr ^ ActAddr) >> 8);

    always_comb begin
        tc_set = '0;
        Mode   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tc_set[i]       = step_ok && step_tc && (StepCh == CH_W'(i));
            Mode[6*i +: 6]  = mode_q[i];
        end
    end

    always_comb begin
        status_byte              = '0;
        status_byte[NUM_CH-1:0]  = tc_flags_q;
        rd_byte                  = '0;
        case (RegSel)
            REG_ADDR:   if (int'(ptr_q) < AB) rd_byte = rd_addr[8*ptr_q +: 8];
            REG_COUNT:  if (int'(ptr_q) < CB) rd_byte = rd_cnt[8*ptr_q +: 8];
            REG_MODE:   rd_byte = {2'b00, mode_q[ChSel]};
            REG_CMD:    rd_byte = command_q;
            REG_STATUS: rd_byte = status_byte;
            default:    rd_byte = '0;
        endcase
    end

    // Shared byte pointer wraps after the last byte of whichever register is accessed.
    always_comb begin
        ptr_d     = ptr_q;
        last_byte = (RegSel == REG_ADDR) ? AB - 1 : CB - 1;
        if (CpuWr && (RegSel == REG_CLRPTR)) begin
            ptr_d = '0;
        end else if ((CpuWr || CpuRd) && ((RegSel == REG_ADDR) || (RegSel == REG_COUNT))) begin
            ptr_d = (int'(ptr_q) >= last_byte) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (clr) begin
            command_q  <= 8'h04;
            tc_flags_q <= '0;
            ptr_q      <= '0;
            cpu_dout_q <= '0;
            tc_q       <= 1'b0;
            adstb_q    <= 1'b0;
            for (int i = 0; i < NCH_P; i++) begin
                mode_q[i]      <= '0;
                base_addr_q[i] <= '0;
                cur_addr_q[i]  <= '0;
                base_cnt_q[i]  <= '0;
                cur_cnt_q[i]   <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            tc_flags_q <= (rd_status ? '0 : tc_flags_q) | tc_set;
            tc_q       <= step_ok && step_tc;
            adstb_q    <= step_ok && !step_reload && addr_carry;
            if (rd_only) cpu_dout_q <= rd_byte;
            if (CpuWr && (RegSel == REG_CMD)) command_q <= CpuDin;

            for (int i = 0; i < NCH_P; i++) begin
                if (step_ok && (StepCh == CH_W'(i))) begin
                    if (step_reload) begin
                        cur_addr_q[i] <= base_addr_q[i];
                        cur_cnt_q[i]  <= base_cnt_q[i];
                    end else begin
                        cur_addr_q[i] <= step_addr;
                        cur_cnt_q[i]  <= ActCount - CNT_W'(1);
                    end
                end
                if (ch_ok && (ChSel == CH_W'(i))) begin
                    if (wr_addr && (int'(ptr_q) < AB)) begin
                        base_addr_q[i][8*ptr_q +: 8] <= CpuDin;
                        cur_addr_q[i][8*ptr_q +: 8]  <= CpuDin;
                    end
                    if (wr_cnt && (int'(ptr_q) < CB)) begin
                        base_cnt_q[i][8*ptr_q +: 8] <= CpuDin;
                        cur_cnt_q[i][8*ptr_q +: 8]  <= CpuDin;
                    end
                    if (CpuWr && (RegSel == REG_MODE)) mode_q[i] <= CpuDin[5:0];
                end
            end
        end
    end

    assign Command  = command_q;
    assign CpuDout  = cpu_dout_q;
    assign Tc       = tc_q;
    assign AdstbReq = adstb_q;

endmodule
